ldpc_bit_deserializer: RTL and testbench
========================================

LDPC_BIT_DESERIALIZER -- requirements
Module: ldpc_bit_deserializer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, giving the assembled word width in bits.
REQ-002 The block SHALL have parameter FRAME_WORDS, default 8, giving the number of words per codeword frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two), giving the output FIFO entry count.
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ser_data_i, input, 1 bit: serial codeword bit from the pad, asynchronous to wb_clk_i, MSB first.
REQ-007 The block SHALL have port ser_frame_i, input, 1 bit: frame enable from the pad, asynchronous, high for the whole frame.
REQ-008 The block SHALL have port word_o, output, WORD_W bits: FIFO head word for the LDPC encoder/decoder core.
REQ-009 The block SHALL have port word_valid_o, output, 1 bit: FIFO non-empty.
REQ-010 The block SHALL have port word_last_o, output, 1 bit: head word is the final word of its frame.
REQ-011 The block SHALL have port word_ready_i, input, 1 bit: the core accepts the head word.
REQ-012 The block SHALL have port fill_o, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port err_o, output, 2 bits: sticky error flags, bit0 framing, bit1 overflow.
REQ-014 The block SHALL have port clr_err_i, input, 1 bit: synchronous clear of err_o.

Function
REQ-015 ser_data_i and ser_frame_i SHALL each pass a two-flop synchronizer before any use; synchronized versions are sdat and sfrm.
REQ-016 The FSM SHALL have states IDLE, RECV and DRAIN.
REQ-017 In IDLE, an sfrm rising edge (previous 0, current 1) SHALL enter RECV and sample sdat as bit WORD_W-1 of word 0 in that same cycle.
REQ-018 In RECV, each cycle with sfrm=1 SHALL shift sdat into the shift register LSB-ward and increment the bit counter (0..WORD_W-1).
REQ-019 When the bit counter reaches WORD_W-1, the block SHALL push the completed word into the FIFO in that cycle, set last=(word counter==FRAME_WORDS-1), reset the bit counter to 0 and increment the word counter.
REQ-020 After the push of word FRAME_WORDS-1, the FSM SHALL go to DRAIN.
REQ-021 In RECV, sfrm=0 SHALL set err_o[0], discard the partial word (already-pushed words remain) and return to IDLE.
REQ-022 DRAIN SHALL ignore sdat and return to IDLE on sfrm=0; any sfrm=1 cycle in DRAIN SHALL set err_o[0] once per frame.
REQ-023 The FIFO SHALL accept a push when not full, or when full with word_ready_i=1 in the same cycle (simultaneous pop and push).
REQ-024 A push rejected because the FIFO is full SHALL drop the word and set err_o[1]; the FSM SHALL continue counting as if the word had been pushed.
REQ-025 A pop SHALL occur when word_valid_o=1 and word_ready_i=1; word_ready_i while empty SHALL be ignored.
REQ-026 word_o and word_last_o SHALL be stable while word_valid_o=1 and word_ready_i=0.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and fill_o SHALL equal pushes minus pops, in the range 0..FIFO_DEPTH.
REQ-028 A pushed word SHALL appear on word_o with word_valid_o=1 in the cycle after its push edge; latency from the final bit stable at the pad to word_valid_o is 3 rising edges.
REQ-029 err_o bits SHALL remain set until clr_err_i=1; if set and clear occur in the same cycle, set SHALL win.

Reset
REQ-030 Assertion of wb_rst_ni=0 SHALL immediately force the FSM to IDLE, clear both synchronizers, the counters, the shift register and the FIFO pointers, and drive word_valid_o=0, word_last_o=0, word_o=0, fill_o=0, err_o=0.
REQ-031 Reset mid-frame SHALL discard all FIFO contents and partial words.
REQ-032 After deassertion, a frame already high SHALL NOT be received; reception SHALL wait for the next sfrm rising edge.

Verification
REQ-033 Scenario: with WORD_W=16, FRAME_WORDS=8 and word_ready_i=1, send 128 bits of 0xA5C3 repeated -> 8 words 0xA5C3, word_last_o=1 on the 8th only, err_o=0.
REQ-034 Scenario: drop ser_frame_i after 40 bits -> 2 words delivered, err_o=2'b01, FSM in IDLE; the next good frame is delivered complete.
REQ-035 Scenario: hold word_ready_i=0 for a full frame -> fill_o reaches 4, words 5..8 are dropped, err_o=2'b10, and the first 4 words are popped intact afterwards.
REQ-036 Scenario: with the FIFO full and word_ready_i=1 in the push cycle -> push accepted, fill_o stays 4, no overflow.
REQ-037 Scenario: hold the frame high 5 bits past 128 -> err_o[0]=1, no 9th word, IDLE after frame low.
REQ-038 Scenario: pulse wb_rst_ni low mid-word 3 -> outputs zero asynchronously, fill_o=0, and no words emerge until a new frame rising edge.

Source files
------------

// File: rtl/ldpc_bit_deserializer.sv
// ldpc_bit_deserializer
//
// Assembles a serial, MSB-first codeword bit stream from the pad into
// WORD_W-bit words and queues them in a small FIFO for the LDPC core.
// Both pad inputs are asynchronous to wb_clk_i and pass a two-flop
// synchronizer before any use.
//
// Ports:
//   wb_clk_i      - single clock, all state on its rising edge
//   wb_rst_ni     - asynchronous active-low reset
//   ser_data_i    - serial codeword bit (pad, asynchronous)
//   ser_frame_i   - frame enable (pad, asynchronous), high for the whole frame
//   word_o        - FIFO head word (zero while the FIFO is empty)
//   word_valid_o  - FIFO non-empty
//   word_last_o   - head word is the final word of its frame
//   word_ready_i  - core accepts the head word
//   fill_o        - FIFO occupancy, 0..FIFO_DEPTH
//   err_o         - sticky errors: bit0 framing, bit1 overflow
//   clr_err_i     - synchronous clear of err_o (a same-cycle set wins)
//   dbg_state     - current FSM state (0 IDLE, 1 RECV, 2 DRAIN)
//
// Handshake: a word transfers on every rising edge where word_valid_o=1 and
// word_ready_i=1. word_o/word_last_o hold steady while word_valid_o=1 and
// word_ready_i=0; word_ready_i is ignored while the FIFO is empty.

module ldpc_bit_deserializer #(
    parameter int WORD_W      = 16,
    parameter int FRAME_WORDS = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          ser_data_i,
    input  logic                          ser_frame_i,
    output logic [WORD_W-1:0]             word_o,
    output logic                          word_valid_o,
    output logic                          word_last_o,
    input  logic                          word_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic [1:0]                    err_o,
    input  logic                          clr_err_i,
    output logic [1:0]                    dbg_state
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int BC_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WC_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(WORD_W - 1);
    localparam logic [WC_W-1:0]   WORD_LAST = WC_W'(FRAME_WORDS - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic              dat_s1, dat_s2, frm_s1, frm_s2;
    logic              sdat, sfrm;
    logic              frm_prev;
    logic [1:0]        settle;
    logic              armed;
    logic [WORD_W-1:0] shift_q;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic              drain_err;

    logic              push_req, push_last, push_ok, pop, full, overflow;
    logic              frm_err;
    logic [WORD_W-1:0] push_word;

    logic [WORD_W-1:0] mem_word [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    assign sdat      = dat_s2;
    assign sfrm      = frm_s2;
    assign dbg_state = state;

    // Two-flop synchronizers. "settle" counts the edges until frm_s2 holds a
    // real pad sample; "armed" is only set once sfrm has been seen low after
    // that, so a frame that was already high across reset is never received.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            dat_s1   <= 1'b0;
            dat_s2   <= 1'b0;
            frm_s1   <= 1'b0;
            frm_s2   <= 1'b0;
            frm_prev <= 1'b0;
            settle   <= 2'd0;
            armed    <= 1'b0;
        end else begin
            dat_s1   <= ser_data_i;
            dat_s2   <= dat_s1;
            frm_s1   <= ser_frame_i;
            frm_s2   <= frm_s1;
            frm_prev <= sfrm;
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            if (settle == 2'd2 && !sfrm)
                armed <= 1'b1;
        end
    end

    always_comb begin
        push_req  = (state == RECV) && sfrm && (bit_cnt == BIT_LAST);
        push_last = (word_cnt == WORD_LAST);
        push_word = {shift_q[WORD_W-2:0], sdat};
        frm_err   = ((state == RECV) && !sfrm) ||
                    ((state == DRAIN) && sfrm && !drain_err);
    end

    // Receive FSM. bit_cnt is the index of the bit arriving this cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            drain_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    drain_err <= 1'b0;
                    word_cnt  <= '0;
                    if (armed && sfrm && !frm_prev) begin
                        state   <= RECV;
                        shift_q <= {{(WORD_W-1){1'b0}}, sdat};
                        bit_cnt <= BC_W'(1);
                    end else begin
                        shift_q <= '0;
                        bit_cnt <= '0;
                    end
                end
                RECV: begin
                    if (!sfrm) begin
                        // Partial word is dropped; words already pushed stay.
                        state <= IDLE;
                    end else begin
                        shift_q <= push_word;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (push_last) begin
                                word_cnt <= '0;
                                state    <= DRAIN;
                            end else begin
                                word_cnt <= word_cnt + WC_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!sfrm)
                        state <= IDLE;
                    else
                        drain_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO: a full FIFO still accepts a push when the head pops in the same
    // cycle. A rejected push drops the word; the FSM counts it regardless.
    always_comb begin
        full     = (fill_o == FILL_MAX);
        pop      = (fill_o != '0) && word_ready_i;
        push_ok  = push_req && (!full || pop);
        overflow = push_req && full && !pop;
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem_word[wr_ptr] <= push_word;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_o <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fill_o <= fill_o + FILL_W'(1);
                2'b01:   fill_o <= fill_o - FILL_W'(1);
                default: fill_o <= fill_o;
            endcase
        end
    end

    // Sticky errors; a set in the same cycle as a clear wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            err_o <= 2'b00;
        else
            err_o <= (clr_err_i ? 2'b00 : err_o) | {overflow, frm_err};
    end

    // Head outputs are forced to zero while empty so reset and empty look alike.
    assign word_valid_o = (fill_o != '0);
    assign word_o       = word_valid_o ? mem_word[rd_ptr] : '0;
    assign word_last_o  = word_valid_o & mem_last[rd_ptr];

endmodule

// File: tb/tb_ldpc_bit_deserializer.sv
// Directed testbench for ldpc_bit_deserializer (WORD_W=16, FRAME_WORDS=8,
// FIFO_DEPTH=4). Inputs are driven 1 ns after the rising edge, outputs are
// sampled on the falling edge. A monitor records every accepted word.

module tb_ldpc_bit_deserializer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_frame = 1'b0;
    logic [15:0] word;
    logic        word_valid;
    logic        word_last;
    logic        word_ready = 1'b0;
    logic [2:0]  fill;
    logic [1:0]  err;
    logic        clr_err = 1'b0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] frame_w [8];
    logic [16:0] got_q [$];   // {last, word} of each accepted word

    ldpc_bit_deserializer #(
        .WORD_W(16), .FRAME_WORDS(8), .FIFO_DEPTH(4)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .ser_data_i   (ser_data),
        .ser_frame_i  (ser_frame),
        .word_o       (word),
        .word_valid_o (word_valid),
        .word_last_o  (word_last),
        .word_ready_i (word_ready),
        .fill_o       (fill),
        .err_o        (err),
        .clr_err_i    (clr_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
        $fatal(1);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready)
            got_q.push_back({word_last, word});
    end

    // ---------------- driver tasks ----------------
    function automatic logic frame_bit(input int i);
        logic [15:0] w;
        if (i >= 128) return 1'b0;
        w = frame_w[i / 16];
        return w[15 - (i % 16)];
    endfunction

    task automatic drive_bit(input logic f, input logic d);
        @(posedge clk);
        #1;
        ser_frame = f;
        ser_data  = d;
    endtask

    task automatic send_frame(input int nbits);
        for (int i = 0; i < nbits; i++)
            drive_bit(1'b1, frame_bit(i));
        drive_bit(1'b0, 1'b0);
        repeat (6) @(posedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while (fill != 3'd0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (fill !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_timeout: fill=%0d required 0", fill);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_err();
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
    endtask

    task automatic load_frame(input logic [15:0] base, input logic [15:0] step);
        for (int k = 0; k < 8; k++)
            frame_w[k] = base + 16'(k) * step;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", word_valid); end
        n_checks++; if (word_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b required 0", word_last); end
        n_checks++; if (word !== 16'h0) begin n_fail++; $display("FAIL reset_word: got %h required 0000", word); end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d required 0", fill); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b required 00", err); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_good_frame();
        for (int k = 0; k < 8; k++) frame_w[k] = 16'hA5C3;
        word_ready = 1'b1;
        got_q.delete();
        send_frame(128);
        wait_drain();
        n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL good_count: got %0d words required 8", got_q.size()); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_q[k] !== {(k == 7), 16'hA5C3}) begin
                n_fail++;
                $display("FAIL good_word%0d: got last=%b word=%h required last=%b word=a5c3",
                         k, got_q[k][16], got_q[k][15:0], (k == 7));
            end
        end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL good_err: got %b required 00", err); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL good_state: got %0d required 0", dbg_state); end
    endtask

    task automatic test_framing_error();
        load_frame(16'h1111, 16'h1111);
        word_ready = 1'b1;
        got_q.delete();
        send_frame(40);
        wait_drain();
        n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL abort_count: got %0d words required 2", got_q.size()); end
        n_checks++; if (got_q[0] !== {1'b0, 16'h1111}) begin n_fail++; $display("FAIL abort_word0: got %h required 01111", got_q[0]); end
        n_checks++; if (got_q[1] !== {1'b0, 16'h2222}) begin n_fail++; $display("FAIL abort_word1: got %h required 02222", got_q[1]); end
        n_checks++; if (err !== 2'b01) begin n_fail++; $display("FAIL abort_err: got %b required 01", err); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d required 0", dbg_state); end
        repeat (5) @(negedge clk);
        n_checks++; if (err !== 2'b01) begin n_fail++; $display("FAIL err_sticky: got %b required 01", err); end
        clear_err();
        @(negedge clk);
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b required 00", err); end
        // next good frame after the abort
        load_frame(16'h0F0F, 16'h0101);
        got_q.delete();
        send_frame(128);
        wait_drain();
        n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL recover_count: got %0d words required 8", got_q.size()); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_q[k] !== {(k == 7), frame_w[k]}) begin
                n_fail++;
                $display("FAIL recover_word%0d: got %h required %b_%h", k, got_q[k], (k == 7), frame_w[k]);
            end
        end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL recover_err: got %b required 00", err); end
    endtask

    task automatic test_overflow();
        load_frame(16'h1357, 16'h2001);
        word_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 128; i++) begin
            drive_bit(1'b1, frame_bit(i));
            @(negedge clk);
            if (i == 17) begin
                n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: valid=%b required 0", word_valid); end
            end
            if (i == 18) begin
                n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: valid=%b required 1", word_valid); end
                n_checks++; if (word !== 16'h1357) begin n_fail++; $display("FAIL latency_word: got %h required 1357", word); end
            end
            if (i == 40) begin
                n_checks++; if (fill !== 3'd2) begin n_fail++; $display("FAIL ovf_fill_mid: got %0d required 2", fill); end
            end
            if (i == 60) begin
                n_checks++;
                if (word !== 16'h1357 || word_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL head_stable: got %h last=%b required 1357 last=0", word, word_last);
                end
            end
        end
        drive_bit(1'b0, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL ovf_fill: got %0d required 4", fill); end
        n_checks++; if (err !== 2'b10) begin n_fail++; $display("FAIL ovf_err: got %b required 10", err); end
        @(posedge clk); #1; word_ready = 1'b1;
        wait_drain();
        n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d words required 4", got_q.size()); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got_q[k] !== {1'b0, frame_w[k]}) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got %h required 0_%h", k, got_q[k], frame_w[k]);
            end
        end
        clear_err();
    endtask

    task automatic test_full_simul();
        load_frame(16'h8421, 16'h0110);
        word_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 128; i++) begin
            drive_bit(1'b1, frame_bit(i));
            // word 4 is pushed on the edge ending bit 82's cycle; pop there too
            if (i == 81) word_ready = 1'b1;
            if (i == 82) word_ready = 1'b0;
            @(negedge clk);
            if (i == 82) begin
                n_checks++; if (fill !== 3'd4) begin n_fail++; $display("FAIL simul_fill: got %0d required 4", fill); end
                n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL simul_err: got %b required 00", err); end
                n_checks++;
                if (got_q.size() !== 1 || got_q[0] !== {1'b0, 16'h8421}) begin
                    n_fail++;
                    $display("FAIL simul_pop: got %0d words first %h required 1 word 08421", got_q.size(), got_q[0]);
                end
            end
        end
        drive_bit(1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1; word_ready = 1'b1;
        wait_drain();
        n_checks++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL simul_count: got %0d words required 5", got_q.size()); end
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (got_q[k] !== {1'b0, frame_w[k]}) begin
                n_fail++;
                $display("FAIL simul_word%0d: got %h required 0_%h", k, got_q[k], frame_w[k]);
            end
        end
        n_checks++; if (err !== 2'b10) begin n_fail++; $display("FAIL simul_err_end: got %b required 10", err); end
        clear_err();
    endtask

    task automatic test_long_frame();
        load_frame(16'hC001, 16'h0203);
        word_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 133; i++) begin
            drive_bit(1'b1, frame_bit(i));
            @(negedge clk);
            if (i == 132) begin
                n_checks++; if (dbg_state !== S_DRAIN) begin n_fail++; $display("FAIL long_drain_state: got %0d required 2", dbg_state); end
            end
        end
        drive_bit(1'b0, 1'b0);
        repeat (6) @(posedge clk);
        wait_drain();
        n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL long_count: got %0d words required 8", got_q.size()); end
        n_checks++; if (got_q[7] !== {1'b1, frame_w[7]}) begin n_fail++; $display("FAIL long_last: got %h required 1_%h", got_q[7], frame_w[7]); end
        n_checks++; if (err !== 2'b01) begin n_fail++; $display("FAIL long_err: got %b required 01", err); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL long_state: got %0d required 0", dbg_state); end
    endtask

    task automatic test_mid_reset();
        // err still holds the framing flag from the long frame
        load_frame(16'h3C3C, 16'h1001);
        word_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 40; i++)
            drive_bit(1'b1, frame_bit(i));
        @(negedge clk);
        n_checks++; if (fill !== 3'd2) begin n_fail++; $display("FAIL prereset_fill: got %0d required 2", fill); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b required 0", word_valid); end
        n_checks++; if (word !== 16'h0) begin n_fail++; $display("FAIL async_word: got %h required 0000", word); end
        n_checks++; if (word_last !== 1'b0) begin n_fail++; $display("FAIL async_last: got %b required 0", word_last); end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL async_fill: got %0d required 0", fill); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL async_err: got %b required 00", err); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL async_state: got %0d required 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        word_ready = 1'b1;
        // frame stays high across reset release: must not be received
        for (int i = 0; i < 30; i++)
            drive_bit(1'b1, 1'($urandom_range(0, 1)));
        @(negedge clk);
        n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL stale_frame: got %0d words required 0", got_q.size()); end
        n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL stale_fill: got %0d required 0", fill); end
        drive_bit(1'b0, 1'b0);
        repeat (6) @(posedge clk);
        send_frame(128);
        wait_drain();
        n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL postreset_count: got %0d words required 8", got_q.size()); end
        n_checks++; if (got_q[0] !== {1'b0, 16'h3C3C}) begin n_fail++; $display("FAIL postreset_first: got %h required 03c3c", got_q[0]); end
        n_checks++; if (got_q[7] !== {1'b1, frame_w[7]}) begin n_fail++; $display("FAIL postreset_last: got %h required 1_%h", got_q[7], frame_w[7]); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_framing_error();
        test_overflow();
        test_full_simul();
        test_long_frame();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
